mips_multicycle_ctrl: RTL and testbench

Multi-cycle control FSM that sequences the MIPS datapath (register file, ALU, PC/IR, unified memory port) one instruction at a time. It decodes the opcode and funct fields held in the instruction register, drives every datapath mux and write enable, and handshakes with memory for instruction fetch, load and store. It sits beside the register file and ALU in the CPU top level and also keeps a retired-instruction counter.

---
 rtl/mips_pkg.sv | 53 +++++
 rtl/mips_alu_decode.sv | 25 ++
 rtl/mips_multicycle_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared states, opcodes, funct codes, ALU codes and mux selects for the multicycle MIPS controller
package mips_pkg;

  typedef enum logic [3:0] {
    S_START    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BEQ_EX   = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_JUMP_EX  = 4'd12,
    S_HALT     = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;
  localparam logic [3:0] ALU_NOR = 4'hC;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic       SRCA_PC   = 1'b0;
  localparam logic       SRCA_REG  = 1'b1;
  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

endpackage

// File: rtl/mips_alu_decode.sv
// rtl/mips_alu_decode.sv - R-type funct field to ALU control code, with a valid flag for unsupported funct
module mips_alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       valid
);

  // Map supported funct codes; anything else is flagged invalid and drives AND (0).
  always_comb begin
    alu_ctrl = ALU_AND;
    valid    = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_NOR:  alu_ctrl = ALU_NOR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with retired-instruction counter; MIPS_CTRL_ILLEGAL_TRAP_EN selects halt-on-illegal
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zeroflag,
  input  logic                mem_ack,
  output logic                mem_read,
  output logic                mem_write,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [3:0]          alu_ctrl,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  localparam state_e ILLEGAL_NEXT    = S_HALT;
  localparam logic   ILLEGAL_RETIRES = 1'b0;
`else
  localparam state_e ILLEGAL_NEXT    = S_FETCH;
  localparam logic   ILLEGAL_RETIRES = 1'b1;
`endif

  state_e              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                retire;
  logic [3:0]          rtype_ctrl;
  logic                rtype_valid;

  mips_alu_decode u_alu_decode (
    .funct    (funct),
    .alu_ctrl (rtype_ctrl),
    .valid    (rtype_valid)
  );

  // State and retired counter registers; reset may land mid-access and aborts it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_START;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next state and Moore outputs, with ack/zero qualification where the datapath needs it.
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REGB;
    alu_ctrl   = ALU_AND;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_ctrl  = ALU_ADD;
        ir_write  = mem_ack;
        pc_write  = mem_ack;
        if (mem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM2;
        alu_ctrl  = ALU_ADD;
        case (opcode)
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ_EX;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP_EX;
          default: begin
            illegal = 1'b1;
            retire  = ILLEGAL_RETIRES;
            state_d = ILLEGAL_NEXT;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ack) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ack) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_RTYPE_EX: begin
        alu_src_a = SRCA_REG;
        alu_ctrl  = rtype_ctrl;
        if (rtype_valid) begin
          state_d = S_RTYPE_WB;
        end else begin
          illegal = 1'b1;
          retire  = ILLEGAL_RETIRES;
          state_d = ILLEGAL_NEXT;
        end
      end
      S_RTYPE_WB: begin
        alu_ctrl  = rtype_ctrl;
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ_EX: begin
        alu_src_a = SRCA_REG;
        alu_ctrl  = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_write  = zeroflag;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP_EX: begin
        pc_src   = PC_SRC_JUMP;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: illegal = 1'b1;
      default: state_d = S_START;
    endcase
  end

  // Retired count wraps naturally at 2^RETIRE_W.
  always_comb begin
    retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, retire};
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [5:0]  opcode, funct;
  logic        zeroflag, mem_ack;
  logic        mem_read, mem_write, iord, ir_write, pc_write;
  logic [1:0]  pc_src, alu_src_b;
  logic        alu_src_a, reg_dst, mem_to_reg, reg_write, illegal;
  logic [3:0]  alu_ctrl;
  logic [31:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  mips_multicycle_ctrl #(.RETIRE_W(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .funct      (funct),
    .zeroflag   (zeroflag),
    .mem_ack    (mem_ack),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal    (illegal),
    .retired    (retired)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Caller must be in FETCH; fetches with an immediate ack and leaves the DUT in DECODE.
  task automatic do_fetch(input logic [5:0] op, input logic [5:0] fn);
    opcode  = op;
    funct   = fn;
    mem_ack = 1'b1;
    #1;
    check("fetch_rd", {31'd0, mem_read}, 32'd1);
    check("fetch_irw", {31'd0, ir_write}, 32'd1);
    check("fetch_pcw", {31'd0, pc_write}, 32'd1);
    check("fetch_srcb", {30'd0, alu_src_b}, 32'd1);
    next_cycle();
    mem_ack = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; opcode = 6'h00; funct = 6'h00; zeroflag = 1'b0; mem_ack = 1'b0;
    next_cycle();
    next_cycle();
    check("rst_rd", {31'd0, mem_read}, 32'd0);
    check("rst_ret", retired, 32'd0);
    check("rst_ill", {31'd0, illegal}, 32'd0);
    reset_n = 1'b1;
    #1;
    check("start_rd", {31'd0, mem_read}, 32'd0);
    next_cycle();

    // add with zero-wait memory: 4 cycles
    do_fetch(6'h00, 6'h20);
    check("add_dec_srcb", {30'd0, alu_src_b}, 32'd3);
    next_cycle();
    check("add_ex_alu", {28'd0, alu_ctrl}, 32'd2);
    check("add_ex_srca", {31'd0, alu_src_a}, 32'd1);
    next_cycle();
    check("add_wb_rw", {31'd0, reg_write}, 32'd1);
    check("add_wb_dst", {31'd0, reg_dst}, 32'd1);
    check("add_wb_alu", {28'd0, alu_ctrl}, 32'd2);
    check("add_wb_ret", retired, 32'd0);
    next_cycle();
    check("add_ret", retired, 32'd1);

    // lw with three wait cycles in MEMRD: 8 cycles
    do_fetch(6'h23, 6'h00);
    next_cycle();
    check("lw_adr_srcb", {30'd0, alu_src_b}, 32'd2);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      check("lw_wait_rd", {31'd0, mem_read}, 32'd1);
      check("lw_wait_iord", {31'd0, iord}, 32'd1);
      next_cycle();
    end
    mem_ack = 1'b1;
    #1;
    check("lw_ack_rd", {31'd0, mem_read}, 32'd1);
    check("lw_ack_iord", {31'd0, iord}, 32'd1);
    next_cycle();
    mem_ack = 1'b0;
    check("lw_wb_m2r", {31'd0, mem_to_reg}, 32'd1);
    check("lw_wb_rw", {31'd0, reg_write}, 32'd1);
    check("lw_wb_dst", {31'd0, reg_dst}, 32'd0);
    next_cycle();
    check("lw_ret", retired, 32'd2);
    check("lw_refetch", {31'd0, mem_read}, 32'd1);

    // beq taken then not taken: 3 cycles each
    do_fetch(6'h04, 6'h00);
    mem_ack = 1'b1;
    zeroflag = 1'b1;
    next_cycle();
    check("beq1_pcw", {31'd0, pc_write}, 32'd1);
    check("beq1_src", {30'd0, pc_src}, 32'd1);
    check("beq1_alu", {28'd0, alu_ctrl}, 32'd6);
    mem_ack = 1'b0;
    next_cycle();
    check("beq1_ret", retired, 32'd3);
    do_fetch(6'h04, 6'h00);
    zeroflag = 1'b0;
    next_cycle();
    check("beq0_pcw", {31'd0, pc_write}, 32'd0);
    check("beq0_src", {30'd0, pc_src}, 32'd1);
    next_cycle();
    check("beq0_ret", retired, 32'd4);

    // nor and slt ALU decode
    do_fetch(6'h00, 6'h27);
    next_cycle();
    check("nor_alu", {28'd0, alu_ctrl}, 32'hC);
    next_cycle();
    next_cycle();
    do_fetch(6'h00, 6'h2A);
    next_cycle();
    check("slt_alu", {28'd0, alu_ctrl}, 32'd7);
    next_cycle();
    next_cycle();
    check("slt_ret", retired, 32'd6);

    // j: 3 cycles
    do_fetch(6'h02, 6'h00);
    next_cycle();
    check("j_pcw", {31'd0, pc_write}, 32'd1);
    check("j_src", {30'd0, pc_src}, 32'd2);
    next_cycle();
    check("j_ret", retired, 32'd7);

    // sw aborted by reset while mem_write is high
    do_fetch(6'h2B, 6'h00);
    next_cycle();
    next_cycle();
    check("sw_wr", {31'd0, mem_write}, 32'd1);
    check("sw_iord", {31'd0, iord}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("sw_rst_wr", {31'd0, mem_write}, 32'd0);
    check("sw_rst_ret", retired, 32'd0);
    next_cycle();
    reset_n = 1'b1;
    #1;
    check("sw_start_rd", {31'd0, mem_read}, 32'd0);
    next_cycle();
    check("sw_fetch_rd", {31'd0, mem_read}, 32'd1);

    // unsupported opcode
    do_fetch(6'h3F, 6'h00);
    check("ill_dec", {31'd0, illegal}, 32'd1);
    next_cycle();
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("halt_ill", {31'd0, illegal}, 32'd1);
      check("halt_rd", {31'd0, mem_read}, 32'd0);
      check("halt_ret", retired, 32'd0);
      next_cycle();
    end
    mem_ack = 1'b0;
    reset_n = 1'b0;
    #1;
    check("halt_rst_ill", {31'd0, illegal}, 32'd0);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    do_fetch(6'h00, 6'h3F);
    next_cycle();
    check("badfn_ill", {31'd0, illegal}, 32'd1);
    next_cycle();
    check("badfn_halt", {31'd0, illegal}, 32'd1);
    check("badfn_ret", retired, 32'd0);
`else
    check("nop_ill", {31'd0, illegal}, 32'd0);
    check("nop_rd", {31'd0, mem_read}, 32'd1);
    check("nop_ret", retired, 32'd1);
    do_fetch(6'h00, 6'h3F);
    next_cycle();
    check("badfn_ill", {31'd0, illegal}, 32'd1);
    next_cycle();
    check("badfn_ill0", {31'd0, illegal}, 32'd0);
    check("badfn_rd", {31'd0, mem_read}, 32'd1);
    check("badfn_ret", retired, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
